// File: rtl/decode_pkg.sv
// Shared decode definitions for the RISC-V decode stage.
// Holds the base opcode constants, the immediate-format enumeration and the
// immediate generator used by decode_comb.
package decode_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Immediate format; the numeric values are visible on io_out_imm_type
    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    // Build the 64-bit sign-extended immediate; callers keep the low XLEN bits
    function automatic logic [63:0] imm_gen(input logic [31:0] inst, input imm_type_e imm_type);
        logic [63:0] imm;
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'h000};
            IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: field extraction, opcode to
// immediate-format mapping, immediate generation, operand-use flags and
// illegal detection. The *-32 opcodes are only legal when XLEN is 64.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output imm_type_e       imm_type_o,
    output logic [XLEN-1:0] imm_o,
    output logic            rd_wen_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o,
    output logic            illegal_o
);

    logic [63:0] imm_full;

    assign opcode_o = inst_i[6:0];
    assign rd_o     = inst_i[11:7];
    assign rs1_o    = inst_i[19:15];
    assign rs2_o    = inst_i[24:20];
    assign funct3_o = inst_i[14:12];
    assign funct7_o = inst_i[31:25];

    // Classify the opcode, then derive immediate and flags; illegal forces all to zero
    always_comb begin
        imm_type_o = IMM_R;
        illegal_o  = 1'b0;
        case (inst_i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: imm_type_o = IMM_I;
            OPC_STORE:  imm_type_o = IMM_S;
            OPC_BRANCH: imm_type_o = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_type_o = IMM_U;
            OPC_JAL:    imm_type_o = IMM_J;
            OPC_OP:     imm_type_o = IMM_R;
            OPC_OP_IMM_32: begin
                if (XLEN == 64) imm_type_o = IMM_I;
                else            illegal_o  = 1'b1;
            end
            OPC_OP_32: begin
                if (XLEN == 64) imm_type_o = IMM_R;
                else            illegal_o  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        // Compressed/non-32-bit encodings are not handled by this stage
        if (inst_i[1:0] != 2'b11) illegal_o = 1'b1;
        if (illegal_o) imm_type_o = IMM_R;

        imm_full   = illegal_o ? 64'd0 : imm_gen(inst_i, imm_type_o);
        rd_wen_o   = !illegal_o && (imm_type_o != IMM_S) && (imm_type_o != IMM_B)
                     && (inst_i[11:7] != 5'd0);
        rs1_used_o = !illegal_o && ((imm_type_o == IMM_R) || (imm_type_o == IMM_I) ||
                                    (imm_type_o == IMM_S) || (imm_type_o == IMM_B));
        rs2_used_o = !illegal_o && ((imm_type_o == IMM_R) || (imm_type_o == IMM_S) ||
                                    (imm_type_o == IMM_B));
    end

    assign imm_o = imm_full[XLEN-1:0];

    // Upper immediate bits are simply discarded on a 32-bit datapath
    generate
        if (XLEN < 64) begin : g_trunc
            logic unused_imm_hi;
            assign unused_imm_hi = ^imm_full[63:XLEN];
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered, valid/ready handshaked RISC-V decode stage.
// decode_comb decodes the incoming instruction; the result is captured in an
// output pipeline register. Optional macro DECODE_SKID_EN adds a skid entry so
// that io_in_ready becomes a register output.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_flush,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [31:0]     io_in_inst,
    input  logic [PC_W-1:0] io_in_pc,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [PC_W-1:0] io_out_pc,
    output logic [6:0]      io_out_opcode,
    output logic [4:0]      io_out_rd,
    output logic [4:0]      io_out_rs1,
    output logic [4:0]      io_out_rs2,
    output logic [2:0]      io_out_funct3,
    output logic [6:0]      io_out_funct7,
    output logic [2:0]      io_out_imm_type,
    output logic [XLEN-1:0] io_out_imm,
    output logic            io_out_rd_wen,
    output logic            io_out_rs1_used,
    output logic            io_out_rs2_used,
    output logic            io_out_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] imm;
        logic            rd_wen;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } entry_t;

    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;
    imm_type_e       dec_type;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rd_wen;
    logic            dec_rs1_used;
    logic            dec_rs2_used;
    logic            dec_illegal;
    entry_t          dec_entry;

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .inst_i     (io_in_inst),
        .opcode_o   (dec_opcode),
        .rd_o       (dec_rd),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .funct3_o   (dec_funct3),
        .funct7_o   (dec_funct7),
        .imm_type_o (dec_type),
        .imm_o      (dec_imm),
        .rd_wen_o   (dec_rd_wen),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used),
        .illegal_o  (dec_illegal)
    );

    // Pack the combinational decode into one pipeline entry
    always_comb begin
        dec_entry          = '0;
        dec_entry.pc       = io_in_pc;
        dec_entry.opcode   = dec_opcode;
        dec_entry.rd       = dec_rd;
        dec_entry.rs1      = dec_rs1;
        dec_entry.rs2      = dec_rs2;
        dec_entry.funct3   = dec_funct3;
        dec_entry.funct7   = dec_funct7;
        dec_entry.imm_type = dec_type;
        dec_entry.imm      = dec_imm;
        dec_entry.rd_wen   = dec_rd_wen;
        dec_entry.rs1_used = dec_rs1_used;
        dec_entry.rs2_used = dec_rs2_used;
        dec_entry.illegal  = dec_illegal;
    end

`ifdef DECODE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   out_free;

    // Ready only depends on skid occupancy, so it comes straight from a flop
    assign io_in_ready = !skid_valid_q;
    assign accept      = io_in_valid && !skid_valid_q && !io_flush;
    assign out_free    = !out_valid_q || io_out_ready;

    // Output register refills from the skid first so order is preserved
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (io_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = accept;
                if (accept) skid_d = dec_entry;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = dec_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_entry;
        end
    end

    // Both entries update on the clock; reset empties and clears them
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    logic load;

    assign io_in_ready = !out_valid_q || io_out_ready;
    assign load        = io_in_valid && io_in_ready && !io_flush;

    // Flush wins, then a new load, then a drain; otherwise the entry holds
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (io_flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_d       = dec_entry;
        end else if (io_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Single output entry; reset clears valid and the whole payload
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end
`endif

    assign io_out_valid    = out_valid_q;
    assign io_out_pc       = out_q.pc;
    assign io_out_opcode   = out_q.opcode;
    assign io_out_rd       = out_q.rd;
    assign io_out_rs1      = out_q.rs1;
    assign io_out_rs2      = out_q.rs2;
    assign io_out_funct3   = out_q.funct3;
    assign io_out_funct7   = out_q.funct7;
    assign io_out_imm_type = out_q.imm_type;
    assign io_out_imm      = out_q.imm;
    assign io_out_rd_wen   = out_q.rd_wen;
    assign io_out_rs1_used = out_q.rs1_used;
    assign io_out_rs2_used = out_q.rs2_used;
    assign io_out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (single-entry build).
// Runs a 32-bit and a 64-bit instance on the same stimulus and checks both
// against a behavioural model every cycle, plus hand-computed literals.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_flush;
    logic        io_in_valid;
    logic        io_out_ready;
    logic [31:0] io_in_inst;
    logic [31:0] io_in_pc;
    logic [63:0] io_in_pc64;

    always #5 clock = ~clock;
    assign io_in_pc64 = {32'h0, io_in_pc};

    // 32-bit instance outputs
    logic        a_in_ready, a_valid, a_rd_wen, a_rs1_used, a_rs2_used, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_imm_type;
    // 64-bit instance outputs
    logic        b_in_ready, b_valid, b_rd_wen, b_rs1_used, b_rs2_used, b_illegal;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_imm_type;

    decode_stage #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(a_in_ready),
        .io_in_inst(io_in_inst), .io_in_pc(io_in_pc),
        .io_out_valid(a_valid), .io_out_ready(io_out_ready),
        .io_out_pc(a_pc), .io_out_opcode(a_opcode), .io_out_rd(a_rd),
        .io_out_rs1(a_rs1), .io_out_rs2(a_rs2), .io_out_funct3(a_funct3),
        .io_out_funct7(a_funct7), .io_out_imm_type(a_imm_type), .io_out_imm(a_imm),
        .io_out_rd_wen(a_rd_wen), .io_out_rs1_used(a_rs1_used),
        .io_out_rs2_used(a_rs2_used), .io_out_illegal(a_illegal)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(b_in_ready),
        .io_in_inst(io_in_inst), .io_in_pc(io_in_pc64),
        .io_out_valid(b_valid), .io_out_ready(io_out_ready),
        .io_out_pc(b_pc), .io_out_opcode(b_opcode), .io_out_rd(b_rd),
        .io_out_rs1(b_rs1), .io_out_rs2(b_rs2), .io_out_funct3(b_funct3),
        .io_out_funct7(b_funct7), .io_out_imm_type(b_imm_type), .io_out_imm(b_imm),
        .io_out_rd_wen(b_rd_wen), .io_out_rs1_used(b_rs1_used),
        .io_out_rs2_used(b_rs2_used), .io_out_illegal(b_illegal)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0]  t;
        logic [63:0] imm;
        logic        rd_wen;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } dec_t;

    // Decode straight from the ISA tables, using signed arithmetic for immediates
    function automatic dec_t model_dec(input logic [31:0] inst, input bit is64);
        dec_t   d;
        longint v;
        logic [6:0] op;
        op = inst[6:0];
        d  = '{t: 3'd0, imm: 64'd0, rd_wen: 1'b0, rs1_used: 1'b0, rs2_used: 1'b0, illegal: 1'b0};
        v  = 0;
        case (op)
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: d.t = 3'd1;
            7'h23: d.t = 3'd2;
            7'h63: d.t = 3'd3;
            7'h37, 7'h17: d.t = 3'd4;
            7'h6F: d.t = 3'd5;
            7'h33: d.t = 3'd0;
            7'h1B: if (is64) d.t = 3'd1; else d.illegal = 1'b1;
            7'h3B: if (is64) d.t = 3'd0; else d.illegal = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.t = 3'd0;
            return d;
        end
        case (d.t)
            3'd1: v = $signed(inst[31:20]);
            3'd2: v = $signed({inst[31:25], inst[11:7]});
            3'd3: v = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            3'd4: v = $signed({inst[31:12], 12'h000});
            3'd5: v = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            default: v = 0;
        endcase
        d.imm      = v;
        d.rd_wen   = (op != 7'h23) && (op != 7'h63) && (inst[11:7] != 5'd0);
        d.rs1_used = (op != 7'h37) && (op != 7'h17) && (op != 7'h6F);
        d.rs2_used = (op == 7'h33) || (op == 7'h3B) || (op == 7'h23) || (op == 7'h63);
        return d;
    endfunction

    // Model of the stage contents: one slot holding the last accepted instruction
    logic        exp_valid = 1'b0;
    logic        exp_zero  = 1'b1;
    logic [31:0] exp_inst  = 32'h0;
    logic [31:0] exp_pc    = 32'h0;

    always @(posedge clock) begin
        if (reset && !io_flush && exp_valid && io_out_ready)
            $display("xfer pc=%08h inst=%08h", exp_pc, exp_inst);
        if (!reset) begin
            exp_valid <= 1'b0;
            exp_zero  <= 1'b1;
        end else if (io_flush) begin
            exp_valid <= 1'b0;
        end else if (io_in_valid && (!exp_valid || io_out_ready)) begin
            exp_valid <= 1'b1;
            exp_zero  <= 1'b0;
            exp_inst  <= io_in_inst;
            exp_pc    <= io_in_pc;
        end else if (io_out_ready) begin
            exp_valid <= 1'b0;
        end
    end

    task automatic cmp_all();
        dec_t        e32, e64;
        logic [31:0] inst, pc;
        inst = exp_zero ? 32'h0 : exp_inst;
        pc   = exp_zero ? 32'h0 : exp_pc;
        e32  = model_dec(inst, 1'b0);
        e64  = model_dec(inst, 1'b1);
        if (exp_zero) begin
            e32 = '{t: 3'd0, imm: 64'd0, rd_wen: 1'b0, rs1_used: 1'b0, rs2_used: 1'b0, illegal: 1'b0};
            e64 = e32;
        end
        chk("a_pc", a_pc, pc);             chk("b_pc", b_pc, pc);
        chk("a_opcode", a_opcode, inst[6:0]);   chk("b_opcode", b_opcode, inst[6:0]);
        chk("a_rd", a_rd, inst[11:7]);     chk("b_rd", b_rd, inst[11:7]);
        chk("a_rs1", a_rs1, inst[19:15]);  chk("b_rs1", b_rs1, inst[19:15]);
        chk("a_rs2", a_rs2, inst[24:20]);  chk("b_rs2", b_rs2, inst[24:20]);
        chk("a_funct3", a_funct3, inst[14:12]); chk("b_funct3", b_funct3, inst[14:12]);
        chk("a_funct7", a_funct7, inst[31:25]); chk("b_funct7", b_funct7, inst[31:25]);
        chk("a_imm_type", a_imm_type, e32.t);   chk("b_imm_type", b_imm_type, e64.t);
        chk("a_imm", a_imm, e32.imm[31:0]);     chk("b_imm", b_imm, e64.imm);
        chk("a_rd_wen", a_rd_wen, e32.rd_wen);  chk("b_rd_wen", b_rd_wen, e64.rd_wen);
        chk("a_rs1_used", a_rs1_used, e32.rs1_used); chk("b_rs1_used", b_rs1_used, e64.rs1_used);
        chk("a_rs2_used", a_rs2_used, e32.rs2_used); chk("b_rs2_used", b_rs2_used, e64.rs2_used);
        chk("a_illegal", a_illegal, e32.illegal);    chk("b_illegal", b_illegal, e64.illegal);
    endtask

    // Compare process: outputs are sampled on the falling edge every cycle
    always @(negedge clock) begin
        chk("a_valid", a_valid, exp_valid);
        chk("b_valid", b_valid, exp_valid);
        chk("a_in_ready", a_in_ready, !exp_valid || io_out_ready);
        chk("b_in_ready", b_in_ready, !exp_valid || io_out_ready);
        if (exp_valid || exp_zero) cmp_all();
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        io_in_valid = 1'b1;
        io_in_inst  = inst;
        io_in_pc    = pc;
        cycle();
    endtask

    logic [31:0] mix_inst [8] = '{32'h00500093, 32'hFE112E23, 32'h002081B3, 32'h123452B7,
                                  32'h0000007F, 32'hFE000CE3, 32'h002081BB, 32'h001000EF};
    dec_t pin;

    initial begin
        reset = 1'b0; io_flush = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b1;
        io_in_inst = 32'h0; io_in_pc = 32'h0;
        repeat (2) cycle();
        chk("rst_valid", a_valid, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_in_ready", a_in_ready, 1);
        reset = 1'b1;

        // Pin the model itself against hand-computed values
        pin = model_dec(32'h00500093, 1'b0); chk("model_addi_imm", pin.imm, 64'd5);
        pin = model_dec(32'hFE112E23, 1'b0); chk("model_sw_imm", pin.imm, 64'hFFFFFFFFFFFFFFFC);
        pin = model_dec(32'h001000EF, 1'b0); chk("model_jal_imm", pin.imm, 64'h800);
        pin = model_dec(32'h0000001B, 1'b0); chk("model_opimm32_ill", pin.illegal, 1);

        // addi x1,x0,5
        send(32'h00500093, 32'h100);
        chk("addi_valid", a_valid, 1);    chk("addi_type", a_imm_type, 1);
        chk("addi_imm", a_imm, 32'd5);    chk("addi_rd", a_rd, 1);
        chk("addi_rd_wen", a_rd_wen, 1);  chk("addi_rs1u", a_rs1_used, 1);
        chk("addi_rs2u", a_rs2_used, 0);
        // sw x1,-4(x2)
        send(32'hFE112E23, 32'h104);
        chk("sw_type", a_imm_type, 2);    chk("sw_imm", a_imm, 32'hFFFFFFFC);
        chk("sw_rs1", a_rs1, 2);          chk("sw_rs2", a_rs2, 1);
        chk("sw_rd_wen", a_rd_wen, 0);
        // beq then jal back-to-back
        send(32'hFE000CE3, 32'h108);
        chk("beq_imm", a_imm, 32'hFFFFFFF8);
        send(32'h001000EF, 32'h10C);
        chk("jal_imm", a_imm, 32'h00000800);
        chk("jal_imm64", b_imm, 64'h800);
        io_in_valid = 1'b0;
        cycle();

        // lui stalled three cycles while the next instruction waits
        io_out_ready = 1'b0;
        send(32'h123452B7, 32'h200);
        send(32'h00A00113, 32'h204);
        repeat (2) cycle();
        chk("lui_imm_held", a_imm, 32'h12345000);
        chk("lui_in_ready", a_in_ready, 0);
        chk("lui_rd", a_rd, 5);
        io_out_ready = 1'b1;
        cycle();
        chk("after_lui_pc", a_pc, 32'h204);
        io_in_valid = 1'b0;
        cycle();
        chk("after_lui_drained", a_valid, 0);

        // Legal / illegal boundary
        send(32'h00000013, 32'h300);
        chk("nop_illegal", a_illegal, 0);
        send(32'h0000007F, 32'h304);
        chk("bad_illegal", a_illegal, 1); chk("bad_rd_wen", a_rd_wen, 0);
        chk("bad_imm", a_imm, 0);
        send(32'h0000001B, 32'h308);
        chk("opimm32_ill32", a_illegal, 1);
        chk("opimm32_type64", b_imm_type, 1); chk("opimm32_ill64", b_illegal, 0);
        send(32'h00500090, 32'h30C);
        chk("compressed_ill", a_illegal, 1);
        io_in_valid = 1'b0;
        cycle();

        // Flush while an entry is held
        io_out_ready = 1'b0;
        send(32'h00500093, 32'h400);
        io_flush = 1'b1;
        send(32'h00A00113, 32'h404);
        chk("flush_valid", a_valid, 0);
        io_flush = 1'b0; io_in_valid = 1'b0;
        cycle();
        chk("flush_dropped", a_valid, 0);
        io_out_ready = 1'b1;

        // Reset mid-stream
        send(32'h123452B7, 32'h500);
        reset = 1'b0;
        send(32'h00500093, 32'h504);
        chk("midrst_valid", a_valid, 0); chk("midrst_pc", a_pc, 0);
        reset = 1'b1;

        // Mixed stream with intermittent backpressure
        for (int i = 0; i < 8; i++) begin
            io_out_ready = (i % 3) != 0;
            send(mix_inst[i], 32'h600 + 32'(i * 4));
        end
        io_in_valid = 1'b0; io_out_ready = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RISC-V instruction decode stage. Successor to the combinational field/immediate decoder.
- Derives the immediate format from the opcode instead of external ctrl strobes. Produces an XLEN-wide sign-extended immediate, register-use/write flags and an illegal flag.
- Holds the result in an output pipeline register with valid/ready flow control.
- Sits between fetch and the register-read/execute stage.

Parameters:
- XLEN, 32, datapath width. Legal values 32 or 64; sets io_imm and io_pc width.
- PC_W, XLEN, width of the program counter passed through.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on clock edge)
- io_flush  in  1  kill in-flight entry and any same-cycle input
- io_in_valid  in  1  fetch offers instruction
- io_in_ready  out  1  stage can accept
- io_in_inst  in  32  raw instruction
- io_in_pc  in  PC_W  instruction address
- io_out_valid  out  1  decoded entry present
- io_out_ready  in  1  downstream accepts
- io_out_pc  out  PC_W  registered pc
- io_out_opcode  out  7  inst[6:0]
- io_out_rd, io_out_rs1, io_out_rs2  out  5 each  inst[11:7], [19:15], [24:20]
- io_out_funct3  out  3  inst[14:12]
- io_out_funct7  out  7  inst[31:25]
- io_out_imm_type  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J
- io_out_imm  out  XLEN  sign-extended immediate
- io_out_rd_wen, io_out_rs1_used, io_out_rs2_used  out  1 each  operand usage
- io_out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (reset==0 at edge): io_out_valid=0. All payload registers cleared to 0. Reset overrides flush and input.
- io_in_ready = !io_out_valid || io_out_ready. Combinational; gives full throughput with 1-cycle latency.
- Load on edge when io_in_valid && io_in_ready && !io_flush. Payload registers then capture the decode and io_out_valid becomes 1.
- Else if io_out_ready: io_out_valid becomes 0.
- Else: hold all outputs stable. Payload must not change while valid && !ready.
- Flush: io_out_valid becomes 0 next edge and the same-cycle input is dropped. io_in_ready keeps its normal value during flush.
- Opcode-to-imm_type map:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011
  - S: STORE 0100011
  - B: BRANCH 1100011
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - R: OP 0110011
  - XLEN==64 only: OP-IMM-32 0011011 is I; OP-32 0111011 is R
- Immediate formats (bit 31 replicated to XLEN):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'h0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R: 0
- Flags:
  - rd_wen = type not in {S, B} && rd != 0 && !illegal
  - rs1_used = type in {R, I, S, B}, except LUI/AUIPC/JAL
  - rs2_used = type in {R, S, B}
- Illegal when inst[1:0] != 2'b11, or the opcode is not in the map (incl. *-32 opcodes when XLEN==32). Illegal entries still flow as valid entries with imm=0, all flags 0, illegal=1.

Optional Feature:
- DECODE_SKID_EN defined: a second skid entry is added, making io_in_ready a register output (= skid empty).
  - On stall the accepted input parks in the skid entry.
  - The skid drains into the output register when it frees; order is preserved.
  - Flush clears both entries.
  - Throughput stays 1/cycle.
- Undefined: single-entry behaviour above.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OPC_LOAD ... OPC_OP_32)
  - imm_type enum constants IMM_R..IMM_J
  - function imm_gen(inst, type) returning 64 bits, truncated to XLEN
- One sub-module, decode_comb: a purely combinational field/imm/flag decode instantiated before the pipeline register.
- With DECODE_SKID_EN, the skid logic stays inline.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle valid=1, imm_type=1, imm=5, rd=1, rd_wen=1, rs1_used=1, rs2_used=0.
- sw x1,-4(x2) (0xFE112E23) → imm_type=2, imm=0xFFFFFFFC, rs1=2, rs2=1, rd_wen=0.
- beq x0,x0,-8 (0xFE000CE3) then jal x1,2048 (0x001000EF) back-to-back → imm 0xFFFFFFF8 then 0x00000800 on consecutive cycles.
- lui x5,0x12345 (0x123452B7) with out_ready=0 for 3 cycles → imm=0x12345000 held stable, in_ready=0, then drains; no loss or duplication.
- Inputs 0x00000013 and 0x0000007F → out_illegal=0 for the first; out_illegal=1, rd_wen=0, imm=0 for the second. With XLEN=32, 0x0000001B → illegal=1; with XLEN=64 it decodes as I-type.
- Valid entry held (out_ready=0), assert io_flush with in_valid=1 → next cycle out_valid=0, flushed input absent. Reset low mid-stream → out_valid=0 next edge.
